inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequences the instruction-fetch stage against a single-beat AXI4 read channel.
- Accepts a fetch request and address from the IF stage, issues the AR transaction, and captures R data.
- Presents the instruction to IF with a valid/ack handshake; inst_valid drives the IF `complete` qualifier.
- Absorbs pipeline flushes (exception/branch/eret) that arrive mid-transaction by draining and discarding the in-flight beat.

Parameters:
- ARID, 4'd0, AXI ID driven on arid and expected on rid.
- ARSIZE, 3'd2, AXI transfer size; 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  IF requests an instruction at fetch_addr; sampled only in IDLE.
- fetch_addr  in  32  PC to fetch.
- flush  in  1  OR of exception/branch/eret flush.
- inst_ack  in  1  IF consumed inst_out; equals pc_wren && dec_wren && ready.
- inst_out  out  32  fetched instruction; 0 on error or misaligned address.
- inst_addr  out  32  address inst_out belongs to.
- inst_valid  out  1  inst_out valid; held until ack or flush.
- fetch_err  out  1  rresp was non-OKAY for the presented instruction.
- busy  out  1  state != IDLE.
- arid  out  4  = ARID.
- araddr  out  32  latched fetch address.
- arlen  out  8  constant 0.
- arsize  out  3  = ARSIZE.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R ID.
- rdata  in  32  R data.
- rresp  in  2  R response.
- rlast  in  1  R last.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset (async, immediate): state = IDLE; arvalid, rready, inst_valid, fetch_err, busy = 0; araddr, inst_out, inst_addr = 0; discard flag = 0. A reset mid-transaction abandons the transaction. The interconnect is reset in the same domain.
- All outputs are registered except arid, arlen and arsize, which are constants.
- IDLE:
  - fetch_req && !flush && fetch_addr[1:0] == 0: latch araddr = inst_addr = fetch_addr; arvalid <= 1; go to ADDR.
  - fetch_req && !flush && fetch_addr[1:0] != 0: no bus access; inst_out <= 0; inst_addr <= fetch_addr; inst_valid <= 1; go to HOLD. IF raises AdEL itself.
- ADDR: arvalid and araddr stay stable until arready.
  - On arvalid && arready: arvalid <= 0; rready <= 1; go to DATA.
  - flush in ADDR: arvalid is not retracted; discard <= 1.
- DATA: rready = 1.
  - Beat with rvalid && rid != ARID: accepted and dropped; stay in DATA.
  - Beat with rvalid && rid == ARID && rlast, and discard or flush set this cycle: drop the beat; rready <= 0; discard <= 0; go to IDLE.
  - Same beat otherwise: inst_out <= (rresp == 0) ? rdata : 0; fetch_err <= (rresp != 0); inst_valid <= 1; rready <= 0; go to HOLD.
- HOLD: inst_valid = 1; inst_out and inst_addr are held.
  - flush: inst_valid <= 0; fetch_err <= 0; go to IDLE. Flush wins over a simultaneous inst_ack.
  - inst_ack: inst_valid <= 0; fetch_err <= 0; go to IDLE.
- Request sampling: fetch_req and fetch_addr are ignored outside IDLE. IF compares inst_addr against its PC if needed.
- Outstanding transactions: at most 1. No new AR is issued before the previous R completes.
- Latency, zero-wait bus: req sampled at cycle 0 → arvalid at 1 → arready at 1 → rvalid at 2 → inst_valid at 3. Next request is accepted no earlier than the cycle after ack.
- Back-to-back boundary: inst_ack at cycle N puts the block in IDLE at N+1; a new fetch_req is sampled at N+1.
- flush in IDLE: the request is ignored that cycle.

Test Plan:
- Reset, then fetch_req with fetch_addr = 0xBFC00000, arready = 1, R beat 0x3C08BFAF OKAY next cycle → araddr = 0xBFC00000, arlen = 0, arsize = 2; inst_out = 0x3C08BFAF, inst_valid = 1 at cycle 3; held until inst_ack, then IDLE.
- arready low for 4 cycles, then rvalid delayed 3 cycles → arvalid/araddr stable throughout; inst_valid asserts exactly 1 cycle after the R beat.
- flush pulse while in ADDR; R beat 0x12345678 arrives → beat consumed; inst_valid never asserts; busy = 0 the cycle after the beat.
- fetch_addr = 0xBFC00002 → no arvalid at any time; inst_out = 0, inst_valid = 1, inst_addr = 0xBFC00002.
- R beat with rresp = 2'b10 → inst_out = 0, fetch_err = 1 until ack; then a beat with rid = 4'd3 arrives first in a later fetch → ignored; the correct-ID beat is presented.
- inst_ack and flush asserted together in HOLD → IDLE; inst_valid = 0 next cycle. Async reset asserted mid-DATA → arvalid = rready = inst_valid = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-beat AXI4 instruction fetch sequencer with flush drain
module inst_fetch_ctrl #(
   parameter logic [3:0] ARID   = 4'd0,
   parameter logic [2:0] ARSIZE = 3'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   input  logic        flush,
   input  logic        inst_ack,
   output logic [31:0] inst_out,
   output logic [31:0] inst_addr,
   output logic        inst_valid,
   output logic        fetch_err,
   output logic        busy,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
   state_t state, state_n;
   logic [31:0] araddr_n, inst_out_n, inst_addr_n;
   logic arvalid_n, rready_n, inst_valid_n, fetch_err_n, discard, discard_n, beat;
   assign arid   = ARID;
   assign arlen  = 8'd0;
   assign arsize = ARSIZE;
   assign beat   = rvalid && rid == ARID && rlast;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         araddr     <= '0;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         inst_out   <= '0;
         inst_addr  <= '0;
         inst_valid <= 1'b0;
         fetch_err  <= 1'b0;
         discard    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         araddr     <= araddr_n;
         arvalid    <= arvalid_n;
         rready     <= rready_n;
         inst_out   <= inst_out_n;
         inst_addr  <= inst_addr_n;
         inst_valid <= inst_valid_n;
         fetch_err  <= fetch_err_n;
         discard    <= discard_n;
         busy       <= state_n != IDLE;
      end
   always_comb begin
      state_n      = state;
      araddr_n     = araddr;
      arvalid_n    = arvalid;
      rready_n     = rready;
      inst_out_n   = inst_out;
      inst_addr_n  = inst_addr;
      inst_valid_n = inst_valid;
      fetch_err_n  = fetch_err;
      discard_n    = discard;
      case (state)
         IDLE: if (fetch_req && !flush) begin
            inst_addr_n = fetch_addr;
            if (fetch_addr[1:0] == 2'b00) begin
               araddr_n  = fetch_addr;
               arvalid_n = 1'b1;
               state_n   = ADDR;
            end else begin
               inst_out_n   = '0;
               inst_valid_n = 1'b1;
               fetch_err_n  = 1'b0;
               state_n      = HOLD;
            end
         end
         ADDR: begin
            discard_n = discard || flush;
            if (arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = DATA;
            end
         end
         // a flush seen at any point of the transaction drains the beat instead of presenting it
         DATA: begin
            discard_n = discard || flush;
            if (beat) begin
               rready_n  = 1'b0;
               discard_n = 1'b0;
               if (discard || flush) state_n = IDLE;
               else begin
                  inst_out_n   = (rresp == 2'b00) ? rdata : '0;
                  fetch_err_n  = rresp != 2'b00;
                  inst_valid_n = 1'b1;
                  state_n      = HOLD;
               end
            end
         end
         HOLD: if (flush || inst_ack) begin
            inst_valid_n = 1'b0;
            fetch_err_n  = 1'b0;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed stimulus with a queued scoreboard checked on inst_valid rising
module tb_inst_fetch_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   logic fetch_req = 1'b0, flush = 1'b0, inst_ack = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
   logic [3:0] rid = '0;
   logic [31:0] rdata = '0;
   logic [1:0] rresp = '0;
   logic [31:0] inst_out, inst_addr, araddr;
   logic inst_valid, fetch_err, busy, arvalid, rready;
   logic [3:0] arid;
   logic [7:0] arlen;
   logic [2:0] arsize;
   typedef struct {logic [31:0] inst; logic [31:0] addr; logic err;} exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0;
   logic prev_valid = 1'b0;
   inst_fetch_ctrl dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .flush(flush), .inst_ack(inst_ack), .inst_out(inst_out), .inst_addr(inst_addr),
      .inst_valid(inst_valid), .fetch_err(fetch_err), .busy(busy), .arid(arid),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [31:0] inst, input logic [31:0] addr, input logic err);
      exp_t e;
      e.inst = inst;
      e.addr = addr;
      e.err  = err;
      sb.push_back(e);
   endtask
   task automatic request(input logic [31:0] addr);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      tick();
      fetch_req  = 1'b0;
      fetch_addr = 32'hFFFF_FFFC;
   endtask
   task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp);
      rvalid = 1'b1;
      rid    = id;
      rdata  = data;
      rresp  = resp;
      rlast  = 1'b1;
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask
   always @(negedge clk) begin
      if (inst_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got inst_out=%h inst_addr=%h expected no instruction", inst_out, inst_addr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_inst_out", inst_out, e.inst);
            chk("sb_inst_addr", inst_addr, e.addr);
            chk("sb_fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
         end
      end
      prev_valid = inst_valid;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      tick();
      tick();
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      reset = 1'b0;
      // basic zero-wait fetch
      arready = 1'b1;
      push(32'h3C08_BFAF, 32'hBFC0_0000, 1'b0);
      request(32'hBFC0_0000);
      chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
      chk("t1_araddr", araddr, 32'hBFC0_0000);
      chk("t1_arlen", {24'd0, arlen}, 32'd0);
      chk("t1_arsize", {29'd0, arsize}, 32'd2);
      chk("t1_arid", {28'd0, arid}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      tick();
      arready = 1'b0;
      chk("t1_rready", {31'd0, rready}, 32'd1);
      chk("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
      chk("t1_valid_c2", {31'd0, inst_valid}, 32'd0);
      r_beat(4'd0, 32'h3C08_BFAF, 2'b00);
      chk("t1_valid_c3", {31'd0, inst_valid}, 32'd1);
      chk("t1_inst", inst_out, 32'h3C08_BFAF);
      tick();
      tick();
      chk("t1_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_hold_inst", inst_out, 32'h3C08_BFAF);
      inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0;
      chk("t1_ack_valid", {31'd0, inst_valid}, 32'd0);
      chk("t1_ack_busy", {31'd0, busy}, 32'd0);
      // back-to-back request, arready held low 4 cycles, rvalid delayed 3
      push(32'h1111_2222, 32'hBFC0_0100, 1'b0);
      request(32'hBFC0_0100);
      for (int i = 0; i < 4; i++) begin
         chk("t2_arvalid_stable", {31'd0, arvalid}, 32'd1);
         chk("t2_araddr_stable", araddr, 32'hBFC0_0100);
         tick();
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_rready", {31'd0, rready}, 32'd1);
         chk("t2_no_valid", {31'd0, inst_valid}, 32'd0);
         tick();
      end
      chk("t2_pre_beat_valid", {31'd0, inst_valid}, 32'd0);
      r_beat(4'd0, 32'h1111_2222, 2'b00);
      chk("t2_post_beat_valid", {31'd0, inst_valid}, 32'd1);
      inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0;
      // flush while in ADDR drains the beat
      request(32'hBFC0_0200);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3_arvalid_kept", {31'd0, arvalid}, 32'd1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      r_beat(4'd0, 32'h1234_5678, 2'b00);
      chk("t3_busy", {31'd0, busy}, 32'd0);
      chk("t3_rready", {31'd0, rready}, 32'd0);
      chk("t3_valid", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("t3_valid_later", {31'd0, inst_valid}, 32'd0);
      // flush in IDLE suppresses the request
      fetch_req  = 1'b1;
      fetch_addr = 32'hBFC0_0280;
      flush      = 1'b1;
      tick();
      fetch_req = 1'b0;
      flush     = 1'b0;
      chk("t3i_busy", {31'd0, busy}, 32'd0);
      chk("t3i_arvalid", {31'd0, arvalid}, 32'd0);
      // misaligned address bypasses the bus
      push(32'd0, 32'hBFC0_0002, 1'b0);
      request(32'hBFC0_0002);
      chk("t4_arvalid", {31'd0, arvalid}, 32'd0);
      chk("t4_valid", {31'd0, inst_valid}, 32'd1);
      chk("t4_inst", inst_out, 32'd0);
      chk("t4_addr", inst_addr, 32'hBFC0_0002);
      inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0;
      chk("t4_arvalid_after", {31'd0, arvalid}, 32'd0);
      // error response
      arready = 1'b1;
      push(32'd0, 32'hBFC0_0300, 1'b1);
      request(32'hBFC0_0300);
      tick();
      r_beat(4'd0, 32'hDEAD_BEEF, 2'b10);
      tick();
      chk("t5_err_held", {31'd0, fetch_err}, 32'd1);
      chk("t5_inst_zero", inst_out, 32'd0);
      inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0;
      chk("t5_err_clr", {31'd0, fetch_err}, 32'd0);
      // foreign-ID beat ignored
      push(32'hAABB_CCDD, 32'hBFC0_0304, 1'b0);
      request(32'hBFC0_0304);
      tick();
      r_beat(4'd3, 32'h9999_9999, 2'b00);
      chk("t5_foreign_valid", {31'd0, inst_valid}, 32'd0);
      chk("t5_foreign_busy", {31'd0, busy}, 32'd1);
      r_beat(4'd0, 32'hAABB_CCDD, 2'b00);
      chk("t5_id_valid", {31'd0, inst_valid}, 32'd1);
      // ack and flush together in HOLD
      inst_ack = 1'b1;
      flush    = 1'b1;
      tick();
      inst_ack = 1'b0;
      flush    = 1'b0;
      chk("t6_valid", {31'd0, inst_valid}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      // async reset in DATA
      request(32'hBFC0_0400);
      tick();
      arready = 1'b0;
      chk("t6_in_data", {31'd0, rready}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("t6_rst_rready", {31'd0, rready}, 32'd0);
      chk("t6_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
